core_reg_master: RTL and testbench

- Initiator side of the core register bus: accepts single read/write commands from the host/control path and drives the req/ack register bus toward the core register block.
- Range-checks each command against the core base address (core_base_addr_t), converts it to a block offset, waits for the responder's ack with a timeout, and returns one response per command.
- Exactly one transaction outstanding at a time.

---
 rtl/core_reg_pkg.sv | 27 ++
 rtl/core_reg_master_if.sv | 36 +++
 rtl/core_reg_master.sv | 120 ++++++++++++
 tb/tb_core_reg_master.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_reg_pkg.sv
// Shared types for the core register bus: base-address layout, master FSM
// states and the latched command seen by the initiator.
package core_reg_pkg;

  localparam int          CORE_REG_ADDR_W        = 16;
  localparam int          CORE_REG_DATA_W        = 32;
  localparam logic [31:0] CORE_REG_TIMEOUT_DATA  = 32'hDEAD_BEEF;

  // Base address of the core block; only the low 16 bits select registers.
  typedef struct packed {
    logic [15:0] rsvd;
    logic [15:0] ADDR;
  } core_base_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } core_reg_mst_state_e;

  typedef struct packed {
    logic                       write;
    logic [CORE_REG_ADDR_W-1:0] addr;
    logic [CORE_REG_DATA_W-1:0] wdata;
  } core_reg_cmd_t;

endpackage

// File: rtl/core_reg_master_if.sv
// Host command, register bus and host response signals of the core register
// master; master = initiator view, slave = host/responder view.
interface core_reg_master_if #(
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [15:0]       cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              reg_req;
  logic              reg_we;
  logic [15:0]       reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_ack;
  logic [DATA_W-1:0] reg_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [7:0]        err_cnt;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, reg_ack, reg_rdata, rsp_ready,
    output cmd_ready, reg_req, reg_we, reg_addr, reg_wdata, rsp_valid, rsp_rdata,
           rsp_err, err_cnt
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, reg_ack, reg_rdata, rsp_ready,
    input  cmd_ready, reg_req, reg_we, reg_addr, reg_wdata, rsp_valid, rsp_rdata,
           rsp_err, err_cnt
  );
endinterface

// File: rtl/core_reg_master.sv
// Initiator of the core register bus: range-checks host commands, issues one
// req/ack transaction at a time with a timeout, and returns one response each.
module core_reg_master
  import core_reg_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_SPAN = 64,
  parameter int TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  core_base_addr_t       base_addr,
  core_reg_master_if.master     bus
);

  localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [16:0]       SPAN_L   = 17'(REG_SPAN);

  core_reg_mst_state_e state_q, state_d;
  core_reg_cmd_t       cmd_q, cmd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                ready_q;

  logic [15:0]         offset;
  logic                range_err;
  logic                unused_base_hi;

  assign unused_base_hi = ^base_addr.rsvd;

  // Underflow is caught by the compare; the wrapped difference is only used in range.
  assign offset    = bus.cmd_addr - base_addr.ADDR;
  assign range_err = (bus.cmd_addr < base_addr.ADDR) || ({1'b0, offset} >= SPAN_L);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          if (range_err) begin
            state_d     = RSP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            cmd_d.write = bus.cmd_write;
            cmd_d.addr  = offset;
            cmd_d.wdata = CORE_REG_DATA_W'(bus.cmd_wdata);
          end
        end
      end

      REQ: begin
        if (bus.reg_ack) begin
          state_d     = RSP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = cmd_q.write ? '0 : bus.reg_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RSP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = DATA_W'(CORE_REG_TIMEOUT_DATA);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RSP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          if (rsp_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
      ready_q     <= (state_d == IDLE);
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.reg_req   = (state_q == REQ);
  assign bus.reg_we    = cmd_q.write;
  assign bus.reg_addr  = cmd_q.addr;
  assign bus.reg_wdata = DATA_W'(cmd_q.wdata);
  assign bus.rsp_valid = (state_q == RSP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_core_reg_master.sv
// Directed self-checking bench for core_reg_master: bus reads/writes, range
// errors, timeout, response backpressure, mid-request reset, err_cnt saturation.
module tb_core_reg_master;
  import core_reg_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  core_base_addr_t base_addr;
  int              n_cmp = 0;
  int              n_err = 0;

  core_reg_master_if #(.DATA_W(32)) bus ();

  core_reg_master #(.DATA_W(32), .REG_SPAN(64), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .base_addr (base_addr),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
    int w = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    while (bus.cmd_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Count reg_req cycles, pulsing reg_ack in request cycle ack_at (0 = never).
  task automatic run_req(input int ack_at, input logic [31:0] rdata, output int cycles);
    cycles = 0;
    while (bus.reg_req === 1'b1 && cycles < 40) begin
      cycles++;
      if (cycles == ack_at) begin
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = rdata;
      end
      tick();
      bus.reg_ack   = 1'b0;
      bus.reg_rdata = 32'h0BAD_0BAD;
    end
  endtask

  task automatic get_rsp(output logic [31:0] rdata, output logic err);
    int w = 0;
    while (bus.rsp_valid !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("rsp_valid_wait", 32'(bus.rsp_valid), 32'd1);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [31:0] rd;
    logic        er;

    reset          = 1'b1;
    base_addr      = '{rsvd: 16'hABCD, ADDR: 16'h1000};
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.reg_ack    = 1'b0;
    bus.reg_rdata  = '0;
    bus.rsp_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_reg_req",   32'(bus.reg_req),   32'd0);
    check("rst_reg_addr",  32'(bus.reg_addr),  32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
    check("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
    reset = 1'b0;
    tick();
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Read in range, ack on the 3rd request cycle
    send_cmd(1'b0, 16'h1004, 32'h0);
    check("rd_reg_addr", 32'(bus.reg_addr), 32'h0004);
    check("rd_reg_we",   32'(bus.reg_we),   32'd0);
    check("rd_cmd_ready_req", 32'(bus.cmd_ready), 32'd0);
    run_req(3, 32'hCAFE_0001, cyc);
    check("rd_req_cycles", 32'(cyc), 32'd3);
    get_rsp(rd, er);
    check("rd_rsp_rdata", rd, 32'hCAFE_0001);
    check("rd_rsp_err",   32'(er), 32'd0);
    check("rd_rsp_done",  32'(bus.rsp_valid), 32'd0);

    // Write with immediate ack
    send_cmd(1'b1, 16'h1010, 32'h1234_5678);
    check("wr_reg_we",    32'(bus.reg_we),  32'd1);
    check("wr_reg_addr",  32'(bus.reg_addr), 32'h0010);
    check("wr_reg_wdata", bus.reg_wdata,    32'h1234_5678);
    run_req(1, 32'hFFFF_FFFF, cyc);
    check("wr_req_cycles", 32'(cyc), 32'd1);
    get_rsp(rd, er);
    check("wr_rsp_rdata", rd, 32'h0);
    check("wr_rsp_err",   32'(er), 32'd0);

    // Range errors just below the base and at offset REG_SPAN
    send_cmd(1'b0, 16'h0FFF, 32'h0);
    check("lo_reg_req", 32'(bus.reg_req), 32'd0);
    get_rsp(rd, er);
    check("lo_rsp_err",   32'(er), 32'd1);
    check("lo_rsp_rdata", rd, 32'h0);
    send_cmd(1'b0, 16'h1040, 32'h0);
    check("hi_reg_req", 32'(bus.reg_req), 32'd0);
    get_rsp(rd, er);
    check("hi_rsp_err",   32'(er), 32'd1);
    check("hi_rsp_rdata", rd, 32'h0);
    check("range_err_cnt", 32'(bus.err_cnt), 32'd2);

    // Last valid offset is accepted
    send_cmd(1'b0, 16'h103F, 32'h0);
    check("top_reg_addr", 32'(bus.reg_addr), 32'h003F);
    run_req(1, 32'h0000_003F, cyc);
    check("top_req_cycles", 32'(cyc), 32'd1);
    get_rsp(rd, er);
    check("top_rsp_err",   32'(er), 32'd0);
    check("top_rsp_rdata", rd, 32'h0000_003F);

    // Timeout, then a late ack two cycles after reg_req falls
    send_cmd(1'b0, 16'h1008, 32'h0);
    run_req(0, 32'h0, cyc);
    check("to_req_cycles", 32'(cyc), 32'd16);
    get_rsp(rd, er);
    check("to_rsp_err",   32'(er), 32'd1);
    check("to_rsp_rdata", rd, 32'hDEAD_BEEF);
    tick();
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'h5555_5555;
    tick();
    bus.reg_ack   = 1'b0;
    tick();
    check("late_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("late_reg_req",   32'(bus.reg_req),   32'd0);
    check("late_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("late_err_cnt",   32'(bus.err_cnt),   32'd3);

    // Response backpressure with a competing command held valid
    send_cmd(1'b0, 16'h1020, 32'h0);
    run_req(1, 32'hA5A5_0F0F, cyc);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 16'h1004;
    bus.cmd_wdata = 32'h7777_7777;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_rdata", bus.rsp_rdata,      32'hA5A5_0F0F);
      check("bp_rsp_err",   32'(bus.rsp_err),   32'd0);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_reg_req",   32'(bus.reg_req),   32'd0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_rsp_done",  32'(bus.rsp_valid), 32'd0);
    check("bp_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
    tick();
    check("bp_no_accept", 32'(bus.reg_req), 32'd0);

    // Reset during the 4th request cycle
    send_cmd(1'b0, 16'h1008, 32'h0);
    tick();
    tick();
    tick();
    check("mid_reg_req_c4", 32'(bus.reg_req), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_reg_req",   32'(bus.reg_req),   32'd0);
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_err_cnt",   32'(bus.err_cnt),   32'd0);
    check("mid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("mid_no_rsp",       32'(bus.rsp_valid), 32'd0);
    check("mid_ready_again",  32'(bus.cmd_ready), 32'd1);

    // err_cnt saturation over 260 range errors
    for (int i = 0; i < 260; i++) begin
      send_cmd(1'b0, 16'h0000, 32'h0);
      get_rsp(rd, er);
    end
    check("sat_last_err", 32'(er), 32'd1);
    check("sat_err_cnt",  32'(bus.err_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
